skid_register: RTL and testbench
================================

// Module: skid_register
// PURPOSE
//   Elastic single-slot pipeline register with valid/ready handshake and a
//   one-entry skid buffer. Upstream-facing companion to the fixed-latency
//   delay register: it lets a stalled consumer back-pressure a producer
//   without a combinational ready path. Every output is driven directly from
//   a flop.
// PARAMETERS
//   DATA_WIDTH   16   width of the DIN and DOUT payload in bits
// PORTS
//   CLK         in   1           clock; all state updates on posedge
//   RESET       in   1           synchronous, active-high reset
//   DIN         in   DATA_WIDTH  upstream payload
//   DIN_VALID   in   1           upstream payload valid
//   DIN_READY   out  1           block can accept DIN this cycle
//   DOUT        out  DATA_WIDTH  downstream payload
//   DOUT_VALID  out  1           DOUT holds a valid word
//   DOUT_READY  in   1           downstream accepts DOUT this cycle
//   OCCUPANCY   out  2           words held: 0, 1 or 2
// BEHAVIOUR
//   - Handshake events:
//       in_fire  = DIN_VALID & DIN_READY
//       out_fire = DOUT_VALID & DOUT_READY
//   - Storage: main register (drives DOUT) and skid register.
//   - States: EMPTY (occ 0), BUSY (occ 1, main valid), FULL (occ 2, main and
//     skid valid).
//   - Outputs:
//       DOUT_VALID = (state != EMPTY)
//       DIN_READY  = (state != FULL)
//       OCCUPANCY  = state encoding (0, 1 or 2)
//     All are registered; no input-to-output combinational path.
//   - Transitions, evaluated at posedge:
//       EMPTY: in_fire                -> BUSY,  main <= DIN
//       BUSY : in_fire &  out_fire    -> BUSY,  main <= DIN
//              in_fire & !out_fire    -> FULL,  skid <= DIN
//             !in_fire &  out_fire    -> EMPTY
//              otherwise              -> hold
//       FULL : out_fire               -> BUSY,  main <= skid
//              otherwise              -> hold
//   - FULL guarantees in_fire = 0, because DIN_READY = 0.
//   - Latency: a word accepted at edge N appears on DOUT with DOUT_VALID = 1
//     after edge N, when EMPTY or when BUSY with a simultaneous out_fire.
//   - Throughput: one word per cycle while DOUT_READY = 1.
//   - Ordering: strict FIFO; no drop or duplication under any ready pattern.
//   - DOUT is stable while DOUT_VALID = 1 and DOUT_READY = 0.
//   - DIN_VALID is ignored while DIN_READY = 0. DOUT_READY is ignored while
//     DOUT_VALID = 0.
//   - Reset:
//       while RESET = 1: DIN_READY = 0, DOUT_VALID = 0, OCCUPANCY = 0,
//                        DOUT = 0, main = skid = 0, state = EMPTY
//       first cycle after RESET falls: DIN_READY = 1
//   - Reset mid-operation discards held words; no out_fire occurs during reset.
// TESTING
//   1. Reset with DIN_VALID = 1 -> DIN_READY = 0, DOUT_VALID = 0, DOUT = 0,
//      OCCUPANCY = 0; one cycle after release DIN_READY = 1.
//   2. Stream 0x0001..0x0010, DOUT_READY = 1 -> DOUT shows 0x0001..0x0010 on
//      consecutive cycles after 1-cycle latency; OCCUPANCY stays 1.
//   3. Send 0xAAAA, 0xBBBB, 0xCCCC with DOUT_READY = 0 ->
//      OCCUPANCY goes 1 then 2, DIN_READY = 0, 0xCCCC held off upstream,
//      DOUT = 0xAAAA stable.
//   4. From (3), raise DOUT_READY for 3 cycles ->
//      DOUT = 0xAAAA, 0xBBBB, 0xCCCC in order; OCCUPANCY 2 -> 1 -> 1 -> 0.
//   5. Random DIN_VALID / DOUT_READY (50%), 10k words -> scoreboard exact
//      order match, no loss, DOUT stable under stall.
//   6. Assert RESET while FULL -> next cycle OCCUPANCY = 0, DOUT_VALID = 0;
//      the pre-reset words are never emitted.

Source files
------------

// File: rtl/skid_register_if.sv
// ============================================================================
// Module   : skid_register_if
// Purpose  : Valid/ready handshake bundle for the skid register, upstream
//            and downstream sides plus the occupancy status.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface skid_register_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] DIN;
  logic                  DIN_VALID;
  logic                  DIN_READY;
  logic [DATA_WIDTH-1:0] DOUT;
  logic                  DOUT_VALID;
  logic                  DOUT_READY;
  logic [1:0]            OCCUPANCY;

  modport master (
    output DIN, DIN_VALID, DOUT_READY,
    input  DIN_READY, DOUT, DOUT_VALID, OCCUPANCY
  );

  modport slave (
    input  DIN, DIN_VALID, DOUT_READY,
    output DIN_READY, DOUT, DOUT_VALID, OCCUPANCY
  );
endinterface

`default_nettype wire

// File: rtl/skid_register.sv
// ============================================================================
// Module   : skid_register
// Purpose  : Elastic single-slot pipeline register with a one-entry skid
//            buffer; every output comes straight from a flop.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module skid_register #(
  parameter int DATA_WIDTH = 16
) (
  input  wire               CLK,
  input  wire               RESET,
  skid_register_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] r_skid;
  logic                  r_din_ready;
  logic                  r_dout_valid;

  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_main_from_din;
  logic                  w_main_from_skid;
  logic                  w_skid_from_din;

  assign w_in_fire  = bus.DIN_VALID & r_din_ready;
  assign w_out_fire = r_dout_valid & bus.DOUT_READY;

  always_comb begin
    w_state_nxt      = r_state;
    w_main_from_din  = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_from_din  = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt     = ST_BUSY;
          w_main_from_din = 1'b1;
        end
      end
      ST_BUSY: begin
        if (w_in_fire && w_out_fire) begin
          w_main_from_din = 1'b1;
        end else if (w_in_fire) begin
          w_state_nxt     = ST_FULL;
          w_skid_from_din = 1'b1;
        end else if (w_out_fire) begin
          w_state_nxt     = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // Upstream is already stalled here, so only a drain can move us.
        if (w_out_fire) begin
          w_state_nxt      = ST_BUSY;
          w_main_from_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= ST_EMPTY;
      r_main       <= '0;
      r_skid       <= '0;
      r_din_ready  <= 1'b0;
      r_dout_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_din_ready  <= (w_state_nxt != ST_FULL);
      r_dout_valid <= (w_state_nxt != ST_EMPTY);
      if (w_main_from_din) begin
        r_main <= bus.DIN;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      if (w_skid_from_din) begin
        r_skid <= bus.DIN;
      end
    end
  end

  assign bus.DIN_READY  = r_din_ready;
  assign bus.DOUT       = r_main;
  assign bus.DOUT_VALID = r_dout_valid;
  assign bus.OCCUPANCY  = r_state;

endmodule

`default_nettype wire

// File: tb/tb_skid_register.sv
// ============================================================================
// Module   : tb_skid_register
// Purpose  : Directed and random stimulus for skid_register, checked against
//            a queue model of the buffered words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_skid_register;

  logic clk;
  logic rst;

  skid_register_if #(.DATA_WIDTH(16)) bus ();

  skid_register #(.DATA_WIDTH(16)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // The model holds the words currently inside the block, oldest first.
  logic [15:0] mq[$];
  bit          m_rst      = 1'b1;
  bit          m_started  = 1'b0;
  int          m_in_count = 0;

  function automatic bit exp_ready();
    return !m_rst && (mq.size() < 2);
  endfunction

  function automatic bit exp_valid();
    return !m_rst && (mq.size() > 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit inf;
    bit outf;
    inf  = bus.DIN_VALID && exp_ready();
    outf = exp_valid() && bus.DOUT_READY;
    if (rst) begin
      mq.delete();
      m_rst = 1'b1;
    end else begin
      if (outf) void'(mq.pop_front());
      if (inf) begin
        mq.push_back(bus.DIN);
        m_in_count++;
      end
      m_rst = 1'b0;
    end
    m_started = 1'b1;
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("occupancy", {30'd0, bus.OCCUPANCY}, mq.size());
      chk("din_ready", {31'd0, bus.DIN_READY}, {31'd0, exp_ready()});
      chk("dout_valid", {31'd0, bus.DOUT_VALID}, {31'd0, exp_valid()});
      if (exp_valid()) chk("dout", {16'd0, bus.DOUT}, {16'd0, mq[0]});
      if (m_rst) chk("dout_reset", {16'd0, bus.DOUT}, 32'd0);
    end
  end

  initial begin
    int budget;

    rst            = 1'b1;
    bus.DIN        = 16'h1234;
    bus.DIN_VALID  = 1'b1;
    bus.DOUT_READY = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_din_ready", {31'd0, bus.DIN_READY}, 32'd0);
    chk("rst_dout_valid", {31'd0, bus.DOUT_VALID}, 32'd0);
    chk("rst_dout", {16'd0, bus.DOUT}, 32'd0);
    chk("rst_occ", {30'd0, bus.OCCUPANCY}, 32'd0);
    rst           = 1'b0;
    bus.DIN_VALID = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, bus.DIN_READY}, 32'd1);

    // Streaming at full rate: each word appears one edge after acceptance.
    bus.DOUT_READY = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      bus.DIN       = 16'(i);
      bus.DIN_VALID = 1'b1;
      @(negedge clk);
      chk("stream_dout", {16'd0, bus.DOUT}, i);
      chk("stream_occ", {30'd0, bus.OCCUPANCY}, 32'd1);
    end
    bus.DIN_VALID = 1'b0;
    @(negedge clk);
    chk("stream_drain_occ", {30'd0, bus.OCCUPANCY}, 32'd0);

    // Stall downstream and fill both slots.
    bus.DOUT_READY = 1'b0;
    bus.DIN        = 16'hAAAA;
    bus.DIN_VALID  = 1'b1;
    @(negedge clk);
    chk("fill_occ1", {30'd0, bus.OCCUPANCY}, 32'd1);
    chk("fill_dout1", {16'd0, bus.DOUT}, 32'h0000AAAA);
    bus.DIN = 16'hBBBB;
    @(negedge clk);
    chk("fill_occ2", {30'd0, bus.OCCUPANCY}, 32'd2);
    chk("fill_ready", {31'd0, bus.DIN_READY}, 32'd0);
    bus.DIN = 16'hCCCC;
    repeat (2) @(negedge clk);
    chk("held_occ", {30'd0, bus.OCCUPANCY}, 32'd2);
    chk("held_dout", {16'd0, bus.DOUT}, 32'h0000AAAA);

    // Release downstream: A, B, C leave in order.
    bus.DOUT_READY = 1'b1;
    @(negedge clk);
    chk("drain_dout_b", {16'd0, bus.DOUT}, 32'h0000BBBB);
    chk("drain_occ_b", {30'd0, bus.OCCUPANCY}, 32'd1);
    @(negedge clk);
    chk("drain_dout_c", {16'd0, bus.DOUT}, 32'h0000CCCC);
    chk("drain_occ_c", {30'd0, bus.OCCUPANCY}, 32'd1);
    bus.DIN_VALID = 1'b0;
    @(negedge clk);
    chk("drain_occ_0", {30'd0, bus.OCCUPANCY}, 32'd0);
    chk("drain_valid_0", {31'd0, bus.DOUT_VALID}, 32'd0);

    // Random traffic on both sides.
    budget = 0;
    begin
      int target;
      target = m_in_count + 10000;
      while (m_in_count < target && budget < 60000) begin
        bus.DIN        = 16'($urandom);
        bus.DIN_VALID  = $urandom_range(0, 1) == 1;
        bus.DOUT_READY = $urandom_range(0, 1) == 1;
        @(negedge clk);
        budget++;
      end
      chk("random_words_accepted", {31'd0, (m_in_count >= target)}, 32'd1);
    end
    bus.DIN_VALID  = 1'b0;
    bus.DOUT_READY = 1'b1;
    budget = 0;
    while (mq.size() != 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    chk("random_drained", mq.size(), 32'd0);

    // Fill, then reset while full; held words must vanish.
    bus.DOUT_READY = 1'b0;
    bus.DIN_VALID  = 1'b1;
    bus.DIN        = 16'hDEAD;
    @(negedge clk);
    bus.DIN = 16'hBEEF;
    @(negedge clk);
    chk("pre_reset_occ", {30'd0, bus.OCCUPANCY}, 32'd2);
    bus.DIN_VALID = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    chk("reset_full_occ", {30'd0, bus.OCCUPANCY}, 32'd0);
    chk("reset_full_valid", {31'd0, bus.DOUT_VALID}, 32'd0);
    chk("reset_full_dout", {16'd0, bus.DOUT}, 32'd0);
    rst            = 1'b0;
    bus.DOUT_READY = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_no_emit", {31'd0, bus.DOUT_VALID}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
